// File: rtl/rdma_axis_pkt_fifo_if.sv
// rtl/rdma_axis_pkt_fifo_if.sv - AXI4-Stream beat interface used by the RDMA packet FIFO
interface rdma_axis_pkt_fifo_if #(
  parameter int DATA_BITS = 512
);
  logic                   tvalid;
  logic                   tready;
  logic [DATA_BITS-1:0]   tdata;
  logic [DATA_BITS/8-1:0] tkeep;
  logic                   tlast;

  modport master (output tvalid, tdata, tkeep, tlast, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/rdma_axis_pkt_fifo.sv
// rtl/rdma_axis_pkt_fifo.sv - AXI4-Stream packet FIFO, cut-through or store-and-forward with oversize release
// RDMA_PKT_FIFO_STATS_EN adds rx_pkts/tx_pkts packet counters.
module rdma_axis_pkt_fifo #(
  parameter int DATA_BITS = 512,
  parameter int DEPTH     = 64,
  parameter bit STORE_FWD = 1'b1
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  rdma_axis_pkt_fifo_if.slave     s_axis,
  rdma_axis_pkt_fifo_if.master    m_axis,
  output logic [$clog2(DEPTH):0]  count,
  output logic [$clog2(DEPTH):0]  pkt_count,
  output logic                    oversize
`ifdef RDMA_PKT_FIFO_STATS_EN
  ,
  output logic [31:0]             rx_pkts,
  output logic [31:0]             tx_pkts
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int KW = DATA_BITS / 8;
  localparam int EW = DATA_BITS + KW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {IDLE, RELEASE} state_t;
  state_t state, state_nxt;
  logic   release_on;

  logic [EW-1:0]        mem [DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic                 in_ready;
  logic                 out_valid, out_last;
  logic [DATA_BITS-1:0] out_data;
  logic [KW-1:0]        out_keep;

  logic          push, pop, buf_empty, buf_has_pkt, eligible;
  logic          out_free, load_buf, load_bypass, wr_en;
  logic [CW-1:0] buf_cnt, count_nxt, pkt_nxt;
  logic [EW-1:0] rd_word;

  assign push    = s_axis.tvalid && in_ready;
  assign pop     = out_valid && m_axis.tready;
  assign buf_cnt = count - CW'(out_valid);
  assign buf_empty = (buf_cnt == '0);
  // A tlast parked in the output register does not make the buffer head releasable.
  assign buf_has_pkt = ((pkt_count - CW'(out_valid && out_last)) != '0);

  always_comb begin
    if (STORE_FWD)
      eligible = !buf_empty && (buf_has_pkt || (release_on && !(out_valid && out_last)));
    else
      eligible = !buf_empty;
  end

  assign out_free    = !out_valid || pop;
  assign load_buf    = out_free && eligible;
  assign load_bypass = !STORE_FWD && out_free && buf_empty && push;
  assign wr_en       = push && !load_bypass;
  assign rd_word     = mem[rd_ptr];

  assign count_nxt = count + CW'(push) - CW'(pop);
  assign pkt_nxt   = pkt_count + CW'(push && s_axis.tlast) - CW'(pop && out_last);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  // A full buffer with no complete packet can never release on its own.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (STORE_FWD && count == FULL && pkt_count == '0) state_nxt = RELEASE;
      RELEASE: if (pop && out_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    release_on = (state == RELEASE);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pkt_count <= '0;
      in_ready  <= 1'b0;
      oversize  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
    end else begin
      count     <= count_nxt;
      pkt_count <= pkt_nxt;
      in_ready  <= (count_nxt < FULL);
      if (wr_en)    wr_ptr <= wr_ptr + 1'b1;
      if (load_buf) rd_ptr <= rd_ptr + 1'b1;
      if (state == IDLE && state_nxt == RELEASE) oversize <= 1'b1;
      if (load_buf)
        {out_last, out_keep, out_data} <= rd_word;
      else if (load_bypass)
        {out_last, out_keep, out_data} <= {s_axis.tlast, s_axis.tkeep, s_axis.tdata};
      if (load_buf || load_bypass) out_valid <= 1'b1;
      else if (pop)                out_valid <= 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (wr_en) mem[wr_ptr] <= {s_axis.tlast, s_axis.tkeep, s_axis.tdata};
  end

`ifdef RDMA_PKT_FIFO_STATS_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rx_pkts <= '0;
      tx_pkts <= '0;
    end else begin
      if (push && s_axis.tlast) rx_pkts <= rx_pkts + 32'd1;
      if (pop && out_last)      tx_pkts <= tx_pkts + 32'd1;
    end
  end
`endif

  assign s_axis.tready = in_ready;
  assign m_axis.tvalid = out_valid;
  assign m_axis.tdata  = out_data;
  assign m_axis.tkeep  = out_keep;
  assign m_axis.tlast  = out_last;
endmodule

// File: doc/rdma_axis_pkt_fifo.md
# rdma_axis_pkt_fifo

Single-clock, parametrised AXI4-Stream packet FIFO for the RDMA data paths in the user (`aclk`) domain. It sits between the clock-crossing stage and the user read/write data interfaces. It decouples bursts, generalised in width and depth. It adds a packet-aware store-and-forward mode with deadlock-free fallback, packet/occupancy status and optional traffic statistics.

## Interface
- `DATA_BITS`, 512: tdata width; tkeep is `DATA_BITS/8`.
- `DEPTH`, 64: total beat capacity, output register included. Power of two, ≥ 4.
- `STORE_FWD`, 1: 1 = forward only complete packets; 0 = cut-through.
- `aclk`  in  1  clock.
- `aresetn`  in  1  asynchronous active-low reset.
- `s_axis`  AXI4S.s  DATA_BITS  input stream (tvalid, tready, tdata, tkeep, tlast).
- `m_axis`  AXI4S.m  DATA_BITS  output stream.
- `count`  out  $clog2(DEPTH)+1  beats held.
- `pkt_count`  out  $clog2(DEPTH)+1  complete packets held (tlast beats written, not yet read).
- `oversize`  out  1  sticky: a store-and-forward release occurred without a complete packet.
- `rx_pkts`, `tx_pkts`  out  32  packet counters. These ports exist only with `RDMA_PKT_FIFO_STATS_EN`.

## Operation
- Storage is a circular buffer with write/read pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH. It is followed by one output register that drives `m_axis`.
- Push: `s_axis.tvalid && s_axis.tready`. Beat stored with tkeep/tlast unmodified.
- `s_axis.tready` is registered. It equals `count < DEPTH` computed from the next-state count. When full, tready is 0 even if a pop happens in the same cycle; it rises the following cycle.
- Pop: `m_axis.tvalid && m_axis.tready`. The output register refills from the buffer in the same cycle when data is eligible, so back-to-back throughput is 1 beat/cycle.
- Eligibility:
  - Cut-through: any stored beat is eligible.
  - Store-and-forward: a beat is eligible when `pkt_count > 0`, or when release mode is active.
- Release-mode state machine, store-and-forward only:
  - IDLE → RELEASE when `count == DEPTH && pkt_count == 0`. `oversize` is set at the same time.
  - In RELEASE, beats drain cut-through.
  - RELEASE → IDLE on the cycle the tlast beat is popped.
- `pkt_count`: +1 on a push with tlast, −1 on a pop with tlast. Both in the same cycle leave it unchanged.
- `count`: +1 on push, −1 on pop. Both leave it unchanged.
- `m_axis.tvalid` holds until accepted. Data, keep and last remain stable while `tvalid && !tready`.
- `oversize` clears only on reset.

## Timing
- Reset (aresetn low, asynchronous): the following outputs are 0 and the FSM is in IDLE:
  - `s_axis.tready`, `m_axis.tvalid`, `m_axis.tdata/tkeep/tlast`
  - `count`, `pkt_count`, `oversize`
  - the stats counters
- `s_axis.tready` rises on the first `aclk` edge after aresetn deasserts.
- Cut-through latency: a beat pushed at cycle t is valid on `m_axis` at t+1 when the FIFO is empty.
- Store-and-forward latency: a tlast pushed at t increments `pkt_count` at t+1. The packet's first beat is valid at t+2 when the output register is empty.
- Reset mid-packet discards all contents. There is no partial output after reset.
- `count`, `pkt_count` and `oversize` are registered and update one cycle after the event.

## Configuration
- `RDMA_PKT_FIFO_STATS_EN` defined:
  - `rx_pkts` increments on each pushed tlast; `tx_pkts` increments on each popped tlast.
  - Both are 32-bit, wrap at 2^32 − 1 → 0, and reset to 0.
- Undefined: the ports and counters are absent, with no other behavioural change.

## Test plan
- DEPTH=64, STORE_FWD=0: push 1 beat (tlast=1, tkeep=all ones) at t → `m_axis.tvalid`=1 at t+1 with identical data; `count`=1 at t+1, 0 after the pop.
- STORE_FWD=1: push 4-beat packet, last beat at t → `m_axis.tvalid` stays 0 until t+2; then 4 beats out back-to-back with `m_axis.tready`=1; `pkt_count` goes 1 → 0.
- STORE_FWD=1: push 70-beat packet into DEPTH=64 → at `count`=64, `oversize`=1 and draining starts; all 70 beats are delivered in order and the FSM returns to IDLE after tlast.
- Fill to 64 with `m_axis.tready`=0 → `s_axis.tready`=0; pop one beat → tready=1 the next cycle and no beat is lost or duplicated. Pointer wrap is checked with 200 random beats.
- Simultaneous push-tlast and pop-tlast → `pkt_count` unchanged. Assert aresetn low mid-packet → all outputs 0 immediately; `count`=0 after release.
- `RDMA_PKT_FIFO_STATS_EN`: send 10 packets, consume 7 → `rx_pkts`=10, `tx_pkts`=7.
